// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and default
// parameter values used by spi_master and spi_clk_gen.
package spi_pkg;

  localparam int unsigned SPI_DATA_LENGTH = 64;
  localparam int unsigned SPI_CLK_DIV     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator. While en_i is high, produces sclk_o with
// CLK_DIV clk cycles high then CLK_DIV clk cycles low, starting with the high
// half. The strobes are combinational and mark the cycle in which sclk_o is
// about to change (it changes at the following clk edge).
//
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   en_i            run the generator; low forces sclk_o low and clears counters
//   sclk_o          registered serial clock, idle low
//   rise_c_o        sclk_o rises at the next edge
//   fall_c_o        sclk_o falls at the next edge
//   period_end_c_o  last clk cycle of a full sclk period
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_c_o,
  output logic fall_c_o,
  output logic period_end_c_o
);

  localparam int unsigned   HW        = $clog2(CLK_DIV) + 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          low_q, low_d;   // 0: high half-period, 1: low half-period
  logic          sclk_q, sclk_d;
  logic          half_start, half_end;

  assign half_start = (hcnt_q == '0);
  assign half_end   = (hcnt_q == HALF_LAST);

  assign rise_c_o       = en_i && !low_q && half_start;
  assign fall_c_o       = en_i &&  low_q && half_start;
  assign period_end_c_o = en_i &&  low_q && half_end;
  assign sclk_o         = sclk_q;

  // Half-period counter and sclk level
  always_comb begin
    hcnt_d = '0;
    low_d  = 1'b0;
    sclk_d = 1'b0;
    if (en_i) begin
      sclk_d = sclk_q;
      if (rise_c_o) begin
        sclk_d = 1'b1;
      end else if (fall_c_o) begin
        sclk_d = 1'b0;
      end
      if (half_end) begin
        hcnt_d = '0;
        low_d  = !low_q;
      end else begin
        hcnt_d = hcnt_q + HW'(1);
        low_d  = low_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      low_q  <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      low_q  <= low_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master (mode-0 style clock, MSB first). A start seen in IDLE captures
// tx_data and runs SETUP -> SHIFT -> HOLD -> GAP. All outputs are registered
// from the current state, so they lag the state register by one cycle.
// A start present in the last GAP cycle chains the next transaction directly.
//
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   start       transaction request
//   tx_data     word to send, captured on acceptance
//   rx_data     last received word, updated with done
//   busy        transaction in progress (through the CS gap)
//   done        one-cycle completion pulse
//   sclk        serial clock, idle low
//   cs          chip select, active-low
//   mosi        serial data out
//   miso        serial data in
//
// Build option: SPI_MASTER_LOOPBACK_EN samples mosi instead of miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int unsigned CLK_DIV     = SPI_CLK_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] tx_data,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sclk,
  output logic                   cs,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int unsigned   BW       = $clog2(DATA_LENGTH) + 1;
  localparam int unsigned   CW       = $clog2(CLK_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LENGTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  spi_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_LENGTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_LENGTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_LENGTH-1:0] rx_q, rx_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic shift_en, sclk_rise, sclk_fall, period_end;
  logic serial_in;

  assign shift_en = (state_q == ST_SHIFT);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (shift_en),
    .sclk_o        (sclk),
    .rise_c_o      (sclk_rise),
    .fall_c_o      (sclk_fall),
    .period_end_c_o(period_end)
  );

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign serial_in   = mosi_q;
`else
  assign serial_in   = miso;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    rx_d    = rx_q;
    mosi_d  = mosi_q;
    cs_d    = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
    busy_d  = (state_q != ST_IDLE);
    // First GAP cycle: transaction complete, publish received word
    done_d  = (state_q == ST_GAP) && (cnt_q == '0);
    if (done_d) begin
      rx_d = rx_sr_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (start) begin
          state_d = ST_SETUP;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          mosi_d  = tx_sr_q[DATA_LENGTH-1];
          tx_sr_d = {tx_sr_q[DATA_LENGTH-2:0], 1'b0};
        end
        if (sclk_fall) begin
          rx_sr_d = {rx_sr_q[DATA_LENGTH-2:0], serial_in};
        end
        if (period_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Held start chains the next transaction after the gap only
          if (start) begin
            state_d = ST_SETUP;
            tx_sr_d = tx_data;
            rx_sr_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      rx_q    <= rx_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an 8-bit/CLK_DIV=2 instance talking to a peripheral
// model, and a 64-bit/CLK_DIV=1 instance whose miso is looped from mosi.
module tb_spi_master;

  localparam int DL8  = 8;
  localparam int CD8  = 2;
  localparam int DL64 = 64;
  localparam int CD64 = 1;
  localparam int DONE8  = 1 + 2 * CD8 * (DL8 + 1);
  localparam int DONE64 = 1 + 2 * CD64 * (DL64 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  tx8 = '0;
  logic [7:0]  rx8;
  logic        busy8, done8, sclk8, cs8, mosi8;
  logic        miso8 = 1'b0;

  logic        start64 = 1'b0;
  logic [63:0] tx64 = '0;
  logic [63:0] rx64;
  logic        busy64, done64, sclk64, cs64, mosi64;
  wire         miso64;
  assign miso64 = mosi64;

  spi_master #(.DATA_LENGTH(DL8), .CLK_DIV(CD8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .tx_data(tx8), .rx_data(rx8),
    .busy(busy8), .done(done8), .sclk(sclk8), .cs(cs8), .mosi(mosi8), .miso(miso8)
  );

  spi_master #(.DATA_LENGTH(DL64), .CLK_DIV(CD64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .tx_data(tx64), .rx_data(rx64),
    .busy(busy64), .done(done64), .sclk(sclk64), .cs(cs64), .mosi(mosi64), .miso(miso64)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: what the master must report as received
  function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] resp);
`ifdef SPI_MASTER_LOOPBACK_EN
    model_rx = tx;
`else
    model_rx = resp;
`endif
  endfunction

  // Peripheral model: new word per CS assertion, shifts a bit out on each sclk rise
  logic [7:0] resp_q[$];
  logic [7:0] cur_resp = '0;
  int         per_idx = -1;
  logic       cs8_prev = 1'b1;
  logic       sclk8_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (cs8_prev && !cs8) begin
      cur_resp = 8'h00;
      if (resp_q.size() > 0) cur_resp = resp_q.pop_front();
      per_idx = 7;
    end
    if (!cs8 && sclk8 && !sclk8_prev && per_idx >= 0) begin
      miso8 = cur_resp[3'(per_idx)];
      per_idx--;
    end
    cs8_prev   = cs8;
    sclk8_prev = sclk8;
  end

  task automatic wait_idle8();
    int k;
    k = 0;
    while (busy8 !== 1'b0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) chk("idle8 timeout", 64'(busy8), 64'd0);
  endtask

  // One 8-bit transaction, optionally pulsing start at edges 5 and 20
  task automatic run8(input logic [7:0] tx, input logic [7:0] resp,
                      input logic [7:0] exp_rx, input bit pulse_extra, input string tag);
    logic [7:0] mosi_cap;
    int rises, done_edge, done_cnt;
    logic prev_s;
    wait_idle8();
    resp_q.push_back(resp);
    @(negedge clk);
    start8 = 1'b1;
    tx8    = tx;
    @(posedge clk); #1;
    start8 = 1'b0;
    tx8    = ~tx;
    mosi_cap = '0; rises = 0; done_edge = -1; done_cnt = 0; prev_s = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk({tag, " cs/busy@1"}, {62'd0, cs8, busy8}, 64'd1);
      if (n == 2) chk({tag, " sclk in setup"}, 64'(sclk8), 64'd0);
      if (sclk8 && !prev_s) begin
        mosi_cap = {mosi_cap[6:0], mosi8};
        rises++;
      end
      prev_s = sclk8;
      if (done8) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = n;
          chk({tag, " cs at done"}, 64'(cs8), 64'd1);
        end
      end
      if (done_edge > 0 && n == done_edge + 1)
        chk({tag, " done+1 done/busy"}, {62'd0, done8, busy8}, 64'd1);
      if (done_edge > 0 && n == done_edge + CD8) begin
        chk({tag, " busy low"}, 64'(busy8), 64'd0);
        break;
      end
      start8 = pulse_extra && (n == 4 || n == 19);
    end
    chk({tag, " done edge"}, 64'(done_edge), 64'(DONE8));
    chk({tag, " rx"}, 64'(rx8), 64'(exp_rx));
    chk({tag, " mosi bits"}, 64'(mosi_cap), 64'(tx));
    chk({tag, " sclk rises"}, 64'(rises), 64'(DL8));
    if (pulse_extra) begin
      repeat (60) begin
        @(posedge clk); #1;
        if (done8) done_cnt++;
      end
      chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, " stays idle"}, 64'(busy8), 64'd0);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] t, r;
    vecs[0] = '{8'hA5, 8'h3C, model_rx(8'hA5, 8'h3C)};
    vecs[1] = '{8'hC3, 8'h5A, model_rx(8'hC3, 8'h5A)};
    vecs[2] = '{8'h00, 8'hFF, model_rx(8'h00, 8'hFF)};
    vecs[3] = '{8'hFF, 8'h00, model_rx(8'hFF, 8'h00)};
    vecs[4] = '{8'h81, 8'h7E, model_rx(8'h81, 8'h7E)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs",   64'(cs8),   64'd1);
    chk("reset sclk", 64'(sclk8), 64'd0);
    chk("reset mosi", 64'(mosi8), 64'd0);
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset rx",   64'(rx8),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 5; i++)
      run8(vecs[i].tx, vecs[i].resp, vecs[i].exp_rx, 1'b0, $sformatf("vec%0d", i));

    // Extra starts during a transaction are ignored
    run8(8'hA5, 8'h3C, model_rx(8'hA5, 8'h3C), 1'b1, "ignore");

    // Randomized transactions
    for (int i = 0; i < 6; i++) begin
      t = 8'($urandom());
      r = 8'($urandom());
      run8(t, r, model_rx(t, r), 1'b0, $sformatf("rand%0d", i));
    end

    // Reset mid-SHIFT aborts without done
    begin
      int dcnt;
      wait_idle8();
      resp_q.push_back(8'h77);
      @(negedge clk);
      start8 = 1'b1;
      tx8 = 8'h5A;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort cs",   64'(cs8),   64'd1);
      chk("abort sclk", 64'(sclk8), 64'd0);
      chk("abort busy", 64'(busy8), 64'd0);
      chk("abort rx",   64'(rx8),   64'd0);
      dcnt = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done8) dcnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
        @(posedge clk); #1;
        if (done8) dcnt++;
      end
      chk("abort no done", 64'(dcnt), 64'd0);
      run8(8'hFF, 8'h96, model_rx(8'hFF, 8'h96), 1'b0, "post-reset");
    end

    // Back-to-back with start held; tx_data changed in flight
    begin
      logic [7:0] cap[2];
      int ndone, csh, d0, d1;
      logic prev_s;
      wait_idle8();
      resp_q.push_back(8'h5C);
      resp_q.push_back(8'hE1);
      @(negedge clk);
      start8 = 1'b1;
      tx8 = 8'h01;
      @(posedge clk); #1;
      tx8 = 8'h80;
      cap[0] = '0; cap[1] = '0; ndone = 0; csh = 0; d0 = -1; d1 = -1; prev_s = 1'b0;
      for (int n = 1; n <= 300; n++) begin
        @(posedge clk); #1;
        if (sclk8 && !prev_s) cap[ndone] = {cap[ndone][6:0], mosi8};
        prev_s = sclk8;
        if (done8) begin
          if (ndone == 0) begin
            d0 = n;
            chk("b2b rx0", 64'(rx8), 64'(model_rx(8'h01, 8'h5C)));
          end else begin
            d1 = n;
            chk("b2b rx1", 64'(rx8), 64'(model_rx(8'h80, 8'hE1)));
          end
          ndone++;
        end else if (ndone == 1 && cs8) begin
          csh++;
        end
        if (n == 40) start8 = 1'b0;
        if (ndone == 2) break;
      end
      chk("b2b cs gap", 64'(csh + 1), 64'(CD8));
      chk("b2b done0 edge", 64'(d0), 64'(DONE8));
      chk("b2b done1 edge", 64'(d1), 64'(DONE8 + DONE8 + CD8 - 1));
      chk("b2b mosi0", 64'(cap[0]), 64'h01);
      chk("b2b mosi1", 64'(cap[1]), 64'h80);
      start8 = 1'b0;
      wait_idle8();
    end

    // 64-bit, CLK_DIV=1, miso looped from mosi
    begin
      logic [63:0] txw, cap;
      int rises, dedge;
      logic prev_s;
      txw = 64'hDEADBEEF_01234567;
      @(negedge clk);
      start64 = 1'b1;
      tx64 = txw;
      @(posedge clk); #1;
      start64 = 1'b0;
      tx64 = '0;
      cap = '0; rises = 0; dedge = -1; prev_s = 1'b0;
      for (int n = 1; n <= 400; n++) begin
        @(posedge clk); #1;
        if (sclk64 && !prev_s) begin
          cap = {cap[62:0], mosi64};
          rises++;
        end
        prev_s = sclk64;
        if (done64 && dedge < 0) begin
          dedge = n;
          chk("w64 cs at done", 64'(cs64), 64'd1);
        end
        if (dedge > 0 && n == dedge + CD64) begin
          chk("w64 busy low", 64'(busy64), 64'd0);
          break;
        end
      end
      chk("w64 done edge", 64'(dedge), 64'(DONE64));
      chk("w64 rises", 64'(rises), 64'(DL64));
      chk("w64 mosi", cap, txw);
      chk("w64 rx", rx64, txw);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
